vfu_result_arbiter: RTL and testbench
=====================================

// Module: vfu_result_arbiter
// PURPOSE
//  Responder side of the lane FUs' VRF result-write handshake (req/gnt).
//  Sits between the lane FUs (ALU, MFPU) and one VRF write port.
//  Arbitrates round-robin, registers the winning write, holds it until the VRF accepts it,
//  and pulses a per-instruction commit flag when the write lands.
// PARAMETERS
//  NrLanes  0      lane count; passed through for vaddr_t sizing only
//  vaddr_t  logic  VRF element address type (width AW = $bits(vaddr_t))
//  (derived, do not change) DataWidth = $bits(elen_t) = 64; strb_t = logic [DataWidth/8-1:0]
// PORTS
//  clk_i               in   1        clock
//  rst_ni              in   1        async reset, active low
//  alu_result_req_i    in   1        ALU write request
//  alu_result_id_i     in   vid_t    ALU instruction id
//  alu_result_addr_i   in   AW       ALU VRF address
//  alu_result_wdata_i  in   64       ALU write data
//  alu_result_be_i     in   8        ALU byte enables
//  alu_result_gnt_o    out  1        ALU request accepted this cycle
//  mfpu_result_*_i/o   --   --       identical set for the MFPU (req, id, addr, wdata, be, gnt)
//  vrf_req_o           out  1        registered write valid toward VRF
//  vrf_id_o            out  vid_t    id of held write
//  vrf_addr_o          out  AW       address of held write
//  vrf_wdata_o         out  64       data of held write
//  vrf_be_o            out  8        byte enables of held write
//  vrf_gnt_i           in   1        VRF consumed held write this cycle
//  vinsn_written_o     out  NrVInsn  one-hot pulse: a write of vinsn[id] committed
// BEHAVIOUR
//  - Reset (async, rst_ni=0): holding reg empty; all outputs 0; RR pointer = ALU. Pending write dropped.
//  - accept = !vrf_req_o | vrf_gnt_i (slot free, or being drained this cycle).
//  - Grant (combinational, same cycle as req):
//    - if accept and exactly one req -> that FU gets gnt;
//    - if both -> FU indicated by RR pointer gets gnt;
//    - never both gnt; no gnt without req or when !accept.
//  - RR pointer: after any grant, points to the FU not granted; unchanged when no grant.
//  - Next edge after a grant: holding reg <= {id, addr, wdata, be}; vrf_req_o = 1.
//    Latency req->vrf_req_o = 1 cycle.
//  - vrf_gnt_i && vrf_req_o:
//    - vinsn_written_o[vrf_id_o] = 1 that same cycle (comb. from held id), else all 0;
//    - if no new grant, vrf_req_o drops next edge;
//    - drain + new grant in same cycle -> reload with no bubble (1 write/cycle sustained).
//  - While vrf_req_o=1 and !vrf_gnt_i: all held fields stable, no FU granted.
//  - vrf_gnt_i with vrf_req_o=0: ignored.
//  - FUs keep req/data stable until gnt; arbiter samples data only on the grant cycle.
//  - be passed unchanged (be=0 still a legal write and still pulses commit).
// TESTING
//  1 reset, ALU req addr=0x10 wdata=0xDEAD be=0xFF, vrf_gnt_i=1 -> alu_gnt same cycle;
//    next cycle vrf_req_o=1 addr=0x10 and vinsn_written_o[id] pulses.
//  2 ALU+MFPU req every cycle, vrf_gnt_i=1 -> grants alternate ALU,MFPU,ALU,...;
//    vrf_req_o stays 1, no bubbles.
//  3 held write, vrf_gnt_i=0 for 5 cycles with MFPU req -> no mfpu_gnt, outputs stable;
//    gnt on cycle 6 -> mfpu_gnt same cycle, new data next cycle.
//  4 only MFPU req for 4 cycles, pointer at MFPU-granted -> MFPU still wins every cycle (no starvation of lone requester).
//  5 rst_ni low while vrf_req_o=1 -> vrf_req_o=0 immediately; no commit pulse;
//    pointer = ALU after release.
//  6 vrf_gnt_i=1 while empty, no reqs -> no pulse, vrf_req_o stays 0.

Source files
------------

// File: rtl/vfu_result_arbiter.sv
// rtl/vfu_result_arbiter.sv - round-robin ALU/MFPU arbiter feeding one registered VRF write port
module vfu_result_arbiter #(
  parameter int unsigned NrLanes   = 0,
  parameter int unsigned NrVInsn   = 8,
  parameter type         vaddr_t   = logic,
  localparam int unsigned AW        = $bits(vaddr_t),
  localparam int unsigned DataWidth = 64,
  localparam int unsigned StrbWidth = DataWidth / 8,
  localparam int unsigned IdW       = (NrVInsn > 1) ? $clog2(NrVInsn) : 1
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  // ALU result request
  input  logic                 alu_result_req_i,
  input  logic [IdW-1:0]       alu_result_id_i,
  input  logic [AW-1:0]        alu_result_addr_i,
  input  logic [DataWidth-1:0] alu_result_wdata_i,
  input  logic [StrbWidth-1:0] alu_result_be_i,
  output logic                 alu_result_gnt_o,
  // MFPU result request
  input  logic                 mfpu_result_req_i,
  input  logic [IdW-1:0]       mfpu_result_id_i,
  input  logic [AW-1:0]        mfpu_result_addr_i,
  input  logic [DataWidth-1:0] mfpu_result_wdata_i,
  input  logic [StrbWidth-1:0] mfpu_result_be_i,
  output logic                 mfpu_result_gnt_o,
  // VRF write port
  output logic                 vrf_req_o,
  output logic [IdW-1:0]       vrf_id_o,
  output logic [AW-1:0]        vrf_addr_o,
  output logic [DataWidth-1:0] vrf_wdata_o,
  output logic [StrbWidth-1:0] vrf_be_o,
  input  logic                 vrf_gnt_i,
  // Commit notification
  output logic [NrVInsn-1:0]   vinsn_written_o
);

  // NrLanes only sizes vaddr_t at the instantiation site; nothing here depends on it.
  if (NrLanes > 32'h0010_0000) begin : g_lane_count_unused
  end

  typedef enum logic {
    RR_ALU  = 1'b0,
    RR_MFPU = 1'b1
  } rr_e;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_e;

  rr_e   rr_q, rr_d;
  slot_e slot_q, slot_d;

  logic accept;
  logic alu_pick, mfpu_pick;
  logic alu_gnt, mfpu_gnt;
  logic any_gnt;

  assign vrf_req_o         = (slot_q == SLOT_FULL);
  assign alu_result_gnt_o  = alu_gnt;
  assign mfpu_result_gnt_o = mfpu_gnt;
  assign any_gnt           = alu_gnt | mfpu_gnt;

  // Arbitration state registers: round-robin pointer and holding-slot occupancy.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_q   <= RR_ALU;
      slot_q <= SLOT_EMPTY;
    end else begin
      rr_q   <= rr_d;
      slot_q <= slot_d;
    end
  end

  // Grant decision and next-state: grant only when the slot is free or draining now;
  // the pointer favours the FU that lost the last grant.
  always_comb begin
    accept    = 1'b0;
    alu_pick  = 1'b0;
    mfpu_pick = 1'b0;
    alu_gnt   = 1'b0;
    mfpu_gnt  = 1'b0;
    rr_d      = rr_q;
    slot_d    = slot_q;

    // Gating with rst_ni keeps grants low while the block is held in reset.
    accept    = rst_ni & ((slot_q == SLOT_EMPTY) | vrf_gnt_i);
    alu_pick  = alu_result_req_i  & (~mfpu_result_req_i | (rr_q == RR_ALU));
    mfpu_pick = mfpu_result_req_i & (~alu_result_req_i  | (rr_q == RR_MFPU));
    alu_gnt   = accept & alu_pick;
    mfpu_gnt  = accept & mfpu_pick;

    if (alu_gnt) begin
      rr_d = RR_MFPU;
    end else if (mfpu_gnt) begin
      rr_d = RR_ALU;
    end

    // A new grant refills the slot even while it drains, so back-to-back writes have no bubble.
    if (alu_gnt || mfpu_gnt) begin
      slot_d = SLOT_FULL;
    end else if ((slot_q == SLOT_FULL) && vrf_gnt_i) begin
      slot_d = SLOT_EMPTY;
    end
  end

  // Holding register: captures the winner's fields on the grant cycle only.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vrf_id_o    <= '0;
      vrf_addr_o  <= '0;
      vrf_wdata_o <= '0;
      vrf_be_o    <= '0;
    end else if (any_gnt) begin
      if (alu_gnt) begin
        vrf_id_o    <= alu_result_id_i;
        vrf_addr_o  <= alu_result_addr_i;
        vrf_wdata_o <= alu_result_wdata_i;
        vrf_be_o    <= alu_result_be_i;
      end else begin
        vrf_id_o    <= mfpu_result_id_i;
        vrf_addr_o  <= mfpu_result_addr_i;
        vrf_wdata_o <= mfpu_result_wdata_i;
        vrf_be_o    <= mfpu_result_be_i;
      end
    end
  end

  // Commit pulse: one-hot on the held id in the cycle the VRF takes the write.
  always_comb begin
    vinsn_written_o = '0;
    for (int i = 0; i < NrVInsn; i++) begin
      vinsn_written_o[i] = vrf_req_o & vrf_gnt_i & (vrf_id_o == IdW'(i));
    end
  end

endmodule

// File: tb/tb_vfu_result_arbiter.sv
// tb/tb_vfu_result_arbiter.sv - directed self-checking bench for vfu_result_arbiter
module tb_vfu_result_arbiter;

  localparam int unsigned NrVInsn = 8;
  localparam int unsigned IdW     = 3;
  localparam int unsigned AW      = 16;

  logic            clk;
  logic            rst_n;
  logic            alu_req, mfpu_req;
  logic [IdW-1:0]  alu_id, mfpu_id;
  logic [AW-1:0]   alu_addr, mfpu_addr;
  logic [63:0]     alu_wdata, mfpu_wdata;
  logic [7:0]      alu_be, mfpu_be;
  logic            alu_gnt, mfpu_gnt;
  logic            vrf_req;
  logic [IdW-1:0]  vrf_id;
  logic [AW-1:0]   vrf_addr;
  logic [63:0]     vrf_wdata;
  logic [7:0]      vrf_be;
  logic            vrf_gnt;
  logic [NrVInsn-1:0] vinsn_written;

  int errors = 0;
  int checks = 0;

  vfu_result_arbiter #(
    .NrLanes (4),
    .NrVInsn (NrVInsn),
    .vaddr_t (logic [AW-1:0])
  ) dut (
    .clk_i               (clk),
    .rst_ni              (rst_n),
    .alu_result_req_i    (alu_req),
    .alu_result_id_i     (alu_id),
    .alu_result_addr_i   (alu_addr),
    .alu_result_wdata_i  (alu_wdata),
    .alu_result_be_i     (alu_be),
    .alu_result_gnt_o    (alu_gnt),
    .mfpu_result_req_i   (mfpu_req),
    .mfpu_result_id_i    (mfpu_id),
    .mfpu_result_addr_i  (mfpu_addr),
    .mfpu_result_wdata_i (mfpu_wdata),
    .mfpu_result_be_i    (mfpu_be),
    .mfpu_result_gnt_o   (mfpu_gnt),
    .vrf_req_o           (vrf_req),
    .vrf_id_o            (vrf_id),
    .vrf_addr_o          (vrf_addr),
    .vrf_wdata_o         (vrf_wdata),
    .vrf_be_o            (vrf_be),
    .vrf_gnt_i           (vrf_gnt),
    .vinsn_written_o     (vinsn_written)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change just after a falling edge; checks follow 1 ns later.
  task automatic next_cycle();
    @(negedge clk);
  endtask

  task automatic set_alu(input logic req, input logic [IdW-1:0] id, input logic [AW-1:0] addr,
                         input logic [63:0] wdata, input logic [7:0] be);
    alu_req = req; alu_id = id; alu_addr = addr; alu_wdata = wdata; alu_be = be;
  endtask

  task automatic set_mfpu(input logic req, input logic [IdW-1:0] id, input logic [AW-1:0] addr,
                          input logic [63:0] wdata, input logic [7:0] be);
    mfpu_req = req; mfpu_id = id; mfpu_addr = addr; mfpu_wdata = wdata; mfpu_be = be;
  endtask

  initial begin
    rst_n = 1'b0;
    vrf_gnt = 1'b0;
    set_alu(1'b1, 3'd0, 16'h0, 64'h0, 8'h0);
    set_mfpu(1'b1, 3'd0, 16'h0, 64'h0, 8'h0);

    // Reset state, with requests present
    next_cycle(); #1;
    check("rst_vrf_req", {63'd0, vrf_req}, 64'd0);
    check("rst_alu_gnt", {63'd0, alu_gnt}, 64'd0);
    check("rst_mfpu_gnt", {63'd0, mfpu_gnt}, 64'd0);
    check("rst_vinsn", {56'd0, vinsn_written}, 64'd0);
    check("rst_addr", {48'd0, vrf_addr}, 64'd0);

    // Test 1: single ALU write
    next_cycle();
    rst_n = 1'b1;
    set_mfpu(1'b0, 3'd0, 16'h0, 64'h0, 8'h0);
    set_alu(1'b1, 3'd3, 16'h0010, 64'hDEAD, 8'hFF);
    vrf_gnt = 1'b1;
    #1;
    check("t1_alu_gnt", {63'd0, alu_gnt}, 64'd1);
    check("t1_mfpu_gnt", {63'd0, mfpu_gnt}, 64'd0);
    check("t1_vinsn_empty", {56'd0, vinsn_written}, 64'd0);
    next_cycle();
    set_alu(1'b0, 3'd0, 16'h0, 64'h0, 8'h0);
    #1;
    check("t1_vrf_req", {63'd0, vrf_req}, 64'd1);
    check("t1_addr", {48'd0, vrf_addr}, 64'h10);
    check("t1_wdata", vrf_wdata, 64'hDEAD);
    check("t1_be", {56'd0, vrf_be}, 64'hFF);
    check("t1_id", {61'd0, vrf_id}, 64'd3);
    check("t1_vinsn", {56'd0, vinsn_written}, 64'h08);
    next_cycle(); #1;
    check("t1_drained", {63'd0, vrf_req}, 64'd0);
    check("t1_vinsn_off", {56'd0, vinsn_written}, 64'd0);

    // Test 2: both FUs request every cycle, pointer freshly reset to ALU
    rst_n = 1'b0;
    #1;
    next_cycle();
    rst_n = 1'b1;
    set_alu(1'b1, 3'd1, 16'h0020, 64'hA1, 8'h11);
    set_mfpu(1'b1, 3'd2, 16'h0040, 64'hB2, 8'h22);
    vrf_gnt = 1'b1;
    for (int i = 0; i < 6; i++) begin
      #1;
      check($sformatf("t2_alu_gnt_%0d", i), {63'd0, alu_gnt}, (i % 2 == 0) ? 64'd1 : 64'd0);
      check($sformatf("t2_mfpu_gnt_%0d", i), {63'd0, mfpu_gnt}, (i % 2 == 1) ? 64'd1 : 64'd0);
      check($sformatf("t2_vrf_req_%0d", i), {63'd0, vrf_req}, (i > 0) ? 64'd1 : 64'd0);
      if (i > 0) begin
        check($sformatf("t2_addr_%0d", i), {48'd0, vrf_addr}, (i % 2 == 1) ? 64'h20 : 64'h40);
        check($sformatf("t2_vinsn_%0d", i), {56'd0, vinsn_written}, (i % 2 == 1) ? 64'h02 : 64'h04);
      end
      next_cycle();
    end
    set_alu(1'b0, 3'd0, 16'h0, 64'h0, 8'h0);
    set_mfpu(1'b0, 3'd0, 16'h0, 64'h0, 8'h0);
    #1;
    check("t2_last_addr", {48'd0, vrf_addr}, 64'h40);
    check("t2_last_vinsn", {56'd0, vinsn_written}, 64'h04);
    next_cycle(); #1;
    check("t2_empty", {63'd0, vrf_req}, 64'd0);

    // Test 3: held write stalls a pending MFPU request
    set_alu(1'b1, 3'd5, 16'h0055, 64'h5555, 8'h0F);
    vrf_gnt = 1'b0;
    #1;
    check("t3_alu_gnt", {63'd0, alu_gnt}, 64'd1);
    next_cycle();
    set_alu(1'b0, 3'd0, 16'h0, 64'h0, 8'h0);
    set_mfpu(1'b1, 3'd6, 16'h0066, 64'h6666, 8'hF0);
    for (int i = 0; i < 5; i++) begin
      #1;
      check($sformatf("t3_stall_gnt_%0d", i), {63'd0, mfpu_gnt}, 64'd0);
      check($sformatf("t3_stall_req_%0d", i), {63'd0, vrf_req}, 64'd1);
      check($sformatf("t3_stall_addr_%0d", i), {48'd0, vrf_addr}, 64'h55);
      check($sformatf("t3_stall_wdata_%0d", i), vrf_wdata, 64'h5555);
      check($sformatf("t3_stall_be_%0d", i), {56'd0, vrf_be}, 64'h0F);
      check($sformatf("t3_stall_vinsn_%0d", i), {56'd0, vinsn_written}, 64'd0);
      next_cycle();
    end
    vrf_gnt = 1'b1;
    #1;
    check("t3_release_gnt", {63'd0, mfpu_gnt}, 64'd1);
    check("t3_release_vinsn", {56'd0, vinsn_written}, 64'h20);

    // Test 4: lone MFPU keeps winning after its own grant
    for (int i = 0; i < 4; i++) begin
      next_cycle(); #1;
      check($sformatf("t4_mfpu_gnt_%0d", i), {63'd0, mfpu_gnt}, 64'd1);
      check($sformatf("t4_alu_gnt_%0d", i), {63'd0, alu_gnt}, 64'd0);
      check($sformatf("t4_addr_%0d", i), {48'd0, vrf_addr}, 64'h66);
      check($sformatf("t4_be_%0d", i), {56'd0, vrf_be}, 64'hF0);
      check($sformatf("t4_vinsn_%0d", i), {56'd0, vinsn_written}, 64'h40);
    end

    // Test 5: ALU grant moves pointer to MFPU, then reset with a write held
    next_cycle();
    set_mfpu(1'b0, 3'd0, 16'h0, 64'h0, 8'h0);
    set_alu(1'b1, 3'd4, 16'h0044, 64'h4444, 8'h3C);
    #1;
    check("t5_alu_gnt", {63'd0, alu_gnt}, 64'd1);
    next_cycle();
    set_alu(1'b0, 3'd0, 16'h0, 64'h0, 8'h0);
    vrf_gnt = 1'b0;
    #1;
    check("t5_held_req", {63'd0, vrf_req}, 64'd1);
    check("t5_held_addr", {48'd0, vrf_addr}, 64'h44);
    vrf_gnt = 1'b1;
    rst_n = 1'b0;
    #1;
    check("t5_rst_req", {63'd0, vrf_req}, 64'd0);
    check("t5_rst_vinsn", {56'd0, vinsn_written}, 64'd0);
    check("t5_rst_addr", {48'd0, vrf_addr}, 64'd0);
    next_cycle();
    rst_n = 1'b1;
    set_alu(1'b1, 3'd4, 16'h0044, 64'h4444, 8'h3C);
    set_mfpu(1'b1, 3'd6, 16'h0066, 64'h6666, 8'hF0);
    #1;
    check("t5_ptr_alu_gnt", {63'd0, alu_gnt}, 64'd1);
    check("t5_ptr_mfpu_gnt", {63'd0, mfpu_gnt}, 64'd0);
    next_cycle();
    set_alu(1'b0, 3'd0, 16'h0, 64'h0, 8'h0);
    set_mfpu(1'b0, 3'd0, 16'h0, 64'h0, 8'h0);
    #1;
    check("t5_post_addr", {48'd0, vrf_addr}, 64'h44);
    check("t5_post_vinsn", {56'd0, vinsn_written}, 64'h10);

    // Test 6: VRF grant while empty is ignored
    for (int i = 0; i < 2; i++) begin
      next_cycle(); #1;
      check($sformatf("t6_req_%0d", i), {63'd0, vrf_req}, 64'd0);
      check($sformatf("t6_vinsn_%0d", i), {56'd0, vinsn_written}, 64'd0);
    end

    // Zero byte-enable write still lands and commits
    set_alu(1'b1, 3'd7, 16'h0077, 64'h7777, 8'h00);
    #1;
    check("be0_alu_gnt", {63'd0, alu_gnt}, 64'd1);
    next_cycle();
    set_alu(1'b0, 3'd0, 16'h0, 64'h0, 8'h0);
    #1;
    check("be0_req", {63'd0, vrf_req}, 64'd1);
    check("be0_be", {56'd0, vrf_be}, 64'h00);
    check("be0_addr", {48'd0, vrf_addr}, 64'h77);
    check("be0_vinsn", {56'd0, vinsn_written}, 64'h80);

    next_cycle();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
